// File: rtl/packet_sink.sv
// rtl/packet_sink.sv - byte-stream packet sink: circular buffer, trailing size check, commit/discard, replay
module packet_sink #(
  parameter int DEPTH     = 256,
  parameter int LEN_DEPTH = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [7:0]  inData,
  input  logic        inDataValid,
  input  logic [7:0]  inDataSize,
  input  logic        inDataSizeValid,
  output logic [7:0]  outData,
  output logic        outValid,
  input  logic        outReady,
  output logic        outLast,
  output logic [7:0]  outLength,
  output logic        sizeError,
  output logic        overflow,
  output logic [15:0] pktCount,
  output logic [15:0] dropCount
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(LEN_DEPTH);
  localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [LW:0] LPTR_ONE = {{LW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, FETCH, STREAM} state_t;

  logic [7:0]    data_mem [DEPTH];
  logic [7:0]    len_mem  [LEN_DEPTH];
  logic [AW:0]   wr_ptr, commit_ptr, rel_ptr, wr_ptr_inc;
  logic [LW:0]   len_wr, len_rd;
  logic [7:0]    byte_count, count_nx, remaining, mem_q;
  logic [AW-1:0] rd_addr;
  logic          drop, drop_nx;
  logic          buf_full, wr_en, len_full, len_empty, pop, xfer;
  logic          rewind_ovf, rewind_size, commit;
  state_t        state, state_nx;

  assign xfer       = (state == STREAM) && outReady;
  // A transfer in the same cycle frees the slot the write needs.
  assign buf_full   = (wr_ptr[AW] != rel_ptr[AW]) && (wr_ptr[AW-1:0] == rel_ptr[AW-1:0]);
  assign wr_en      = inDataValid && (!buf_full || xfer);
  assign wr_ptr_inc = wr_en ? wr_ptr + PTR_ONE : wr_ptr;
  assign count_nx   = (inDataValid && byte_count != 8'hFF) ? byte_count + 8'd1 : byte_count;
  assign drop_nx    = drop || (inDataValid && !wr_en);

  assign len_full   = (len_wr[LW] != len_rd[LW]) && (len_wr[LW-1:0] == len_rd[LW-1:0]);
  assign len_empty  = (len_wr == len_rd);
  assign pop        = (state == IDLE) && !len_empty;

  assign rewind_ovf  = inDataSizeValid && (drop_nx || len_full);
  assign rewind_size = inDataSizeValid && !rewind_ovf &&
                       (count_nx == 8'd0 || count_nx != inDataSize);
  assign commit      = inDataSizeValid && !rewind_ovf && !rewind_size;

  // Read address tracks the release pointer one cycle ahead, so mem_q always holds the head byte.
  assign rd_addr = xfer ? rel_ptr[AW-1:0] + PTR_ONE[AW-1:0] : rel_ptr[AW-1:0];

  always_ff @(posedge CLK) begin
    if (wr_en) data_mem[wr_ptr[AW-1:0]] <= inData;
    if (commit) len_mem[len_wr[LW-1:0]] <= count_nx;
    mem_q <= data_mem[rd_addr];
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr     <= '0;
      commit_ptr <= '0;
      len_wr     <= '0;
      byte_count <= 8'd0;
      drop       <= 1'b0;
      sizeError  <= 1'b0;
      overflow   <= 1'b0;
      pktCount   <= 16'd0;
      dropCount  <= 16'd0;
    end else begin
      sizeError <= rewind_size;
      overflow  <= rewind_ovf;
      if (inDataSizeValid) begin
        byte_count <= 8'd0;
        drop       <= 1'b0;
      end else begin
        byte_count <= count_nx;
        drop       <= drop_nx;
      end
      if (rewind_ovf || rewind_size) begin
        wr_ptr <= commit_ptr;
        if (dropCount != 16'hFFFF) dropCount <= dropCount + 16'd1;
      end else begin
        wr_ptr <= wr_ptr_inc;
      end
      if (commit) begin
        commit_ptr <= wr_ptr_inc;
        len_wr     <= len_wr + LPTR_ONE;
        if (pktCount != 16'hFFFF) pktCount <= pktCount + 16'd1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= IDLE;
      rel_ptr   <= '0;
      len_rd    <= '0;
      remaining <= 8'd0;
      outLength <= 8'd0;
    end else begin
      state <= state_nx;
      if (pop) begin
        outLength <= len_mem[len_rd[LW-1:0]];
        remaining <= len_mem[len_rd[LW-1:0]];
        len_rd    <= len_rd + LPTR_ONE;
      end
      if (xfer) begin
        rel_ptr   <= rel_ptr + PTR_ONE;
        remaining <= remaining - 8'd1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    outValid = 1'b0;
    outData  = 8'd0;
    outLast  = 1'b0;
    case (state)
      IDLE:   if (pop) state_nx = FETCH;
      FETCH:  state_nx = STREAM;
      STREAM: begin
        outValid = 1'b1;
        outData  = mem_q;
        outLast  = (remaining == 8'd1);
        if (xfer && remaining == 8'd1) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_packet_sink.sv
// tb/tb_packet_sink.sv - directed self-checking bench for packet_sink (DEPTH=16, LEN_DEPTH=2)
module tb_packet_sink;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [7:0]  inData;
  logic        inDataValid;
  logic [7:0]  inDataSize;
  logic        inDataSizeValid;
  logic [7:0]  outData;
  logic        outValid;
  logic        outReady;
  logic        outLast;
  logic [7:0]  outLength;
  logic        sizeError;
  logic        overflow;
  logic [15:0] pktCount;
  logic [15:0] dropCount;

  int checks = 0;
  int errors = 0;
  int exp_pkts = 0;
  int exp_drops = 0;
  logic [7:0] exp_q [$];

  always #5 CLK = ~CLK;

  packet_sink #(.DEPTH(16), .LEN_DEPTH(2)) dut (
    .CLK(CLK), .RESET(RESET),
    .inData(inData), .inDataValid(inDataValid),
    .inDataSize(inDataSize), .inDataSizeValid(inDataSizeValid),
    .outData(outData), .outValid(outValid), .outReady(outReady),
    .outLast(outLast), .outLength(outLength),
    .sizeError(sizeError), .overflow(overflow),
    .pktCount(pktCount), .dropCount(dropCount)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    inData = b;
    inDataValid = 1'b1;
    step();
    inDataValid = 1'b0;
  endtask

  task automatic send_size(input logic [7:0] s);
    inDataSize = s;
    inDataSizeValid = 1'b1;
    step();
    inDataSizeValid = 1'b0;
  endtask

  task automatic send_one(input logic [7:0] b);
    inData = b;
    inDataValid = 1'b1;
    inDataSize = 8'd1;
    inDataSizeValid = 1'b1;
    step();
    inDataValid = 1'b0;
    inDataSizeValid = 1'b0;
  endtask

  task automatic wait_valid(output int t);
    t = 0;
    while (outValid !== 1'b1 && t < 40) begin
      step();
      t++;
    end
  endtask

  task automatic recv_pkt(input string tag, input int gap);
    int t;
    int n;
    n = exp_q.size();
    wait_valid(t);
    if (gap >= 0) chk({tag, "_gap"}, t, gap);
    for (int i = 0; i < n; i++) begin
      chk({tag, "_valid"}, 32'(outValid), 1);
      chk({tag, "_data"}, 32'(outData), 32'(exp_q[i]));
      chk({tag, "_last"}, 32'(outLast), (i == n - 1) ? 1 : 0);
      chk({tag, "_len"}, 32'(outLength), n);
      step();
    end
    chk({tag, "_end"}, 32'(outValid), 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, 32'(outValid), 0);
    chk({tag, "_data"}, 32'(outData), 0);
    chk({tag, "_last"}, 32'(outLast), 0);
    chk({tag, "_len"}, 32'(outLength), 0);
    chk({tag, "_serr"}, 32'(sizeError), 0);
    chk({tag, "_ovf"}, 32'(overflow), 0);
    chk({tag, "_pkts"}, 32'(pktCount), 0);
    chk({tag, "_drops"}, 32'(dropCount), 0);
  endtask

  initial begin
    RESET = 1'b1;
    inData = 8'd0;
    inDataValid = 1'b0;
    inDataSize = 8'd0;
    inDataSizeValid = 1'b0;
    outReady = 1'b0;
    step();
    step();
    chk_all_zero("reset");
    RESET = 1'b0;
    step();

    // single packet with exact two-cycle commit-to-valid latency
    outReady = 1'b1;
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_size(8'd3);
    chk("t1_serr", 32'(sizeError), 0);
    chk("t1_ovf", 32'(overflow), 0);
    chk("t1_lat0", 32'(outValid), 0);
    step();
    chk("t1_lat1", 32'(outValid), 0);
    step();
    exp_q = '{8'h11, 8'h22, 8'h33};
    recv_pkt("t1", 0);
    exp_pkts = 1;
    chk("t1_pkts", 32'(pktCount), exp_pkts);

    // size mismatch discarded, next packet intact
    for (int i = 1; i <= 4; i++) send_byte(8'(i));
    send_size(8'd3);
    chk("t2_serr_pulse", 32'(sizeError), 1);
    chk("t2_ovf", 32'(overflow), 0);
    step();
    chk("t2_serr_clear", 32'(sizeError), 0);
    exp_drops = 1;
    chk("t2_drops", 32'(dropCount), exp_drops);
    repeat (3) step();
    chk("t2_no_out", 32'(outValid), 0);
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_size(8'd2);
    exp_q = '{8'hAA, 8'hBB};
    recv_pkt("t2", 2);
    exp_pkts = 2;
    chk("t2_pkts", 32'(pktCount), exp_pkts);

    // backpressure after the second byte
    for (int i = 1; i <= 5; i++) send_byte(8'(i));
    send_size(8'd5);
    begin
      int t;
      wait_valid(t);
    end
    chk("t3_b1", 32'(outData), 1);
    step();
    chk("t3_b2", 32'(outData), 2);
    step();
    outReady = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t3_hold_data", 32'(outData), 3);
      chk("t3_hold_valid", 32'(outValid), 1);
      chk("t3_hold_last", 32'(outLast), 0);
      chk("t3_hold_len", 32'(outLength), 5);
      step();
    end
    outReady = 1'b1;
    for (int i = 3; i <= 5; i++) begin
      chk("t3_data", 32'(outData), i);
      chk("t3_last", 32'(outLast), (i == 5) ? 1 : 0);
      step();
    end
    chk("t3_end", 32'(outValid), 0);
    exp_pkts = 3;

    // buffer overflow with the output stalled
    outReady = 1'b0;
    for (int i = 0; i < 10; i++) send_byte(8'(8'h40 + i));
    send_size(8'd10);
    chk("t4_first_ovf", 32'(overflow), 0);
    exp_pkts = 4;
    for (int i = 0; i < 10; i++) send_byte(8'(8'h60 + i));
    send_size(8'd10);
    chk("t4_ovf_pulse", 32'(overflow), 1);
    chk("t4_serr", 32'(sizeError), 0);
    step();
    chk("t4_ovf_clear", 32'(overflow), 0);
    exp_drops = 2;
    chk("t4_drops", 32'(dropCount), exp_drops);
    outReady = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 10; i++) exp_q.push_back(8'(8'h40 + i));
    recv_pkt("t4a", -1);
    repeat (4) step();
    chk("t4_no_second", 32'(outValid), 0);
    exp_q.delete();
    for (int i = 0; i < 6; i++) begin
      send_byte(8'(8'h80 + i));
      exp_q.push_back(8'(8'h80 + i));
    end
    send_size(8'd6);
    recv_pkt("t4b", 2);
    exp_pkts = 5;
    chk("t4_pkts", 32'(pktCount), exp_pkts);

    // length FIFO full: one packet in replay plus two queued, the next is discarded
    outReady = 1'b0;
    send_one(8'hC1);
    chk("t5_ovf1", 32'(overflow), 0);
    send_one(8'hC2);
    chk("t5_ovf2", 32'(overflow), 0);
    send_one(8'hC3);
    chk("t5_ovf3", 32'(overflow), 0);
    send_one(8'hC4);
    chk("t5_ovf4", 32'(overflow), 1);
    exp_drops = 3;
    outReady = 1'b1;
    exp_q = '{8'hC1};
    recv_pkt("t5a", -1);
    exp_q = '{8'hC2};
    recv_pkt("t5b", 2);
    exp_q = '{8'hC3};
    recv_pkt("t5c", 2);
    repeat (4) step();
    chk("t5_no_fourth", 32'(outValid), 0);
    exp_pkts = 8;
    chk("t5_pkts", 32'(pktCount), exp_pkts);
    chk("t5_drops", 32'(dropCount), exp_drops);

    // reset during replay and during an incoming packet
    outReady = 1'b0;
    send_byte(8'h50);
    send_byte(8'h51);
    send_size(8'd2);
    step();
    step();
    chk("t6_replaying", 32'(outValid), 1);
    send_byte(8'h52);
    send_byte(8'h53);
    RESET = 1'b1;
    step();
    chk_all_zero("t6_rst");
    RESET = 1'b0;
    outReady = 1'b1;
    send_byte(8'h71);
    send_byte(8'h72);
    send_byte(8'h73);
    send_size(8'd3);
    chk("t6_serr", 32'(sizeError), 0);
    chk("t6_ovf", 32'(overflow), 0);
    exp_q = '{8'h71, 8'h72, 8'h73};
    recv_pkt("t6", 2);
    chk("t6_pkts", 32'(pktCount), 1);
    chk("t6_drops", 32'(dropCount), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
